mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and consumes its ALU result as a data address. It performs 32-bit loads and stores over a 16-bit, two-beat request/acknowledge memory port, and stalls the upstream pipeline with `freeze` while an access is in flight. It ends in the MEM/WB pipeline register feeding write-back.

## Interface
- `DATA_BASE`, default 1024: byte address where data memory starts; subtracted from the ALU result.
- `ADDR_W`, default 18: width of the half-word memory address.
- `TIMEOUT`, default 64: cycles to wait for `mem_ack` per beat; used only with the configuration macro.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `MEM_R_EN` in 1: load request from the EXE/MEM register.
- `MEM_W_EN` in 1: store request from the EXE/MEM register.
- `WB_EN_in` in 1: write-back enable, passed through.
- `Dest_in` in 5: destination register, passed through.
- `ALU_result` in 32: execute-stage result; the byte address for memory operations.
- `ST_val` in 32: store data.
- `freeze` out 1: stalls PC, IF/ID, ID/EX and EXE/MEM registers.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: beat is a write.
- `mem_addr` out ADDR_W: half-word address.
- `mem_wdata` out 16: write half.
- `mem_rdata` in 16: read half.
- `mem_ack` in 1: beat complete. Read data is valid in the same cycle.
- `WB_EN` out 1: registered write-back enable.
- `MEM_R_EN_out` out 1: registered; selects `MEM_result` in the write-back stage.
- `Dest` out 5: registered destination register.
- `ALU_result_out` out 32: registered ALU result.
- `MEM_result` out 32: registered load data.
- `mem_err` out 1: sticky timeout flag. Exists only with the configuration macro.

## Operation
- **Address computation**
  - word index = (`ALU_result` − `DATA_BASE`) >> 2, 32-bit unsigned wrap.
  - `mem_addr` = {word index[ADDR_W-2:0], beat}. Beat is 0 for the low half and 1 for the high half.
  - `ALU_result[1:0]` is ignored; there are no unaligned accesses.
- **State machine**
  - IDLE: if `MEM_R_EN` or `MEM_W_EN` is high, go to LO; otherwise stay in IDLE.
  - LO: `mem_req`=1, beat 0. On `mem_ack`, go to HI.
  - HI: `mem_req`=1, beat 1. On `mem_ack`, go to DONE.
  - DONE: go to IDLE unconditionally.
- **Request outputs**
  - `mem_we` = `MEM_W_EN` during LO and HI.
  - `mem_wdata` = `ST_val[15:0]` in LO and `ST_val[31:16]` in HI.
  - `mem_we` and `mem_wdata` are 0 outside LO and HI.
  - `mem_addr` is 0 in IDLE and DONE.
- **Load capture**
  - On the LO ack, `mem_rdata` goes into an internal low-half register.
  - On the HI ack, `MEM_result` is loaded with {`mem_rdata`, low-half register} at the DONE clock edge.
- **Freeze**
  - `freeze` = (IDLE and (`MEM_R_EN` or `MEM_W_EN`)) or LO or HI. It is combinational, so the upstream registers hold the instruction.
  - `freeze`=0 in DONE, so the instruction advances at the end of DONE.
- **MEM/WB register**
  - Loads `WB_EN`, `MEM_R_EN_out`, `Dest` and `ALU_result_out` every cycle in which `freeze`=0.
  - Holds while `freeze`=1.
  - `MEM_result` updates only on load completion and otherwise holds its value.
- **Read and write together**: if `MEM_R_EN` and `MEM_W_EN` are both high, the access is a store and `MEM_R_EN_out` still passes through.
- **Non-memory instructions** flow through with no stall.

## Timing
- **Reset**: every output is 0 and the state is IDLE.
  - Reset mid-access drops `mem_req` immediately and abandons the access. No retry.
- **Load/store latency**: 4 cycles minimum, when `mem_ack` is high in the first LO and HI cycles. `freeze` is high for 3 of them.
- **Ack stalls**: each cycle of `mem_ack` delay adds one cycle.
- **Non-memory instruction**: 1 cycle.
- **Request hold**: `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and no ack has arrived.
- **Ack outside LO/HI** is ignored.
- **Back-to-back memory instructions**: DONE is followed by IDLE, which sees the next instruction and asserts `freeze` in that same cycle.

## Configuration
- **`MEM_STAGE_TIMEOUT_EN` defined**
  - A per-beat counter resets on entering LO or HI.
  - If it reaches `TIMEOUT` without an ack, the FSM goes to DONE.
  - On a timed-out load, `MEM_result` = 32'hDEAD_BEEF.
  - `mem_err` is set and stays set until `rst`.
- **`MEM_STAGE_TIMEOUT_EN` undefined**: the FSM waits indefinitely for `mem_ack`, and the `mem_err` port is absent.

## Structure
- **Package `mem_stage_pkg`**: state enum (IDLE, LO, HI, DONE), `DATA_BASE` default, beat encodings, and the 32'hDEAD_BEEF poison constant.
- **Sub-module `mem_access_fsm`**
  - Contains the state machine, beat sequencing, the request drivers, the low-half register, and the timeout counter.
  - `mem_stage` wraps it with address computation, `freeze`, and the MEM/WB register.

## Test plan
- **Reset**: assert `rst` asynchronously mid-cycle → all outputs 0 immediately.
- **Non-memory instruction**: `ALU_result`=0x0000_0040, `WB_EN_in`=1, `Dest_in`=5 → `freeze` stays 0, and one cycle later `ALU_result_out`=0x40, `Dest`=5.
- **Store**: `ST_val`=0x1234_5678 to address 1032, ack immediate.
  - Beat 1: `mem_addr`=4, `mem_wdata`=0x5678, `mem_we`=1.
  - Beat 2: `mem_addr`=5, `mem_wdata`=0x1234.
  - `freeze` is high for exactly 3 cycles.
- **Load with ack delay**: address 1024, `mem_rdata` 0xBEEF then 0xCAFE, each ack delayed 2 cycles → `MEM_result`=0xCAFE_BEEF, `freeze` high for 7 cycles.
- **Reset in HI**: assert `rst` while in HI → `mem_req`=0 immediately, and after release a new load completes normally.
- **Timeout (macro on)**: `TIMEOUT`=4 and no ack → DONE after 4 cycles in LO, `mem_err`=1, `MEM_result`=0xDEAD_BEEF.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: FSM states,
// beat encodings, default data base address and the timeout poison word.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          DATA_BASE_DEF = 1024;
  localparam logic        BEAT_LO       = 1'b0;
  localparam logic        BEAT_HI       = 1'b1;
  localparam logic [31:0] POISON        = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_access_fsm.sv
// Two-beat request/ack sequencer for 32-bit accesses over a 16-bit port.
// With MEM_STAGE_TIMEOUT_EN defined, a per-beat timeout forces completion and sets mem_err.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] st_val,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        idle,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  output logic        beat,
  output logic        ld_valid,
  output logic [31:0] ld_data
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  state_t      state;
  logic [15:0] lo_half;
  logic        start;
  logic        is_load;
  logic        tmo;

  assign start   = rd_en | wr_en;
  assign is_load = rd_en & ~wr_en;
  assign idle    = (state == IDLE);
  assign busy    = (state == LO) | (state == HI);

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  assign tmo = busy & ~mem_ack & (cnt == CNT_W'(TIMEOUT - 1));

  // Counter restarts whenever a beat begins, i.e. on entry to LO or HI.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      if ((idle & start) | ((state == LO) & mem_ack))
        cnt <= '0;
      else if (busy)
        cnt <= cnt + 1'b1;
      if (tmo)
        mem_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign tmo        = 1'b0;
  assign unused_cfg = (TIMEOUT == 0);
`endif

  assign ld_valid = is_load & (((state == HI) & mem_ack) | tmo);
  assign ld_data  = tmo ? POISON : {mem_rdata, lo_half};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      beat      <= BEAT_LO;
      lo_half   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= LO;
          mem_req   <= 1'b1;
          mem_we    <= wr_en;
          mem_wdata <= st_val[15:0];
          beat      <= BEAT_LO;
        end
        LO: if (mem_ack) begin
          state     <= HI;
          lo_half   <= mem_rdata;
          mem_wdata <= st_val[31:16];
          beat      <= BEAT_HI;
        end else if (tmo) begin
          state     <= DONE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          beat      <= BEAT_LO;
        end
        HI: if (mem_ack | tmo) begin
          state     <= DONE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          beat      <= BEAT_LO;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: address translation, upstream freeze and MEM/WB register.
// Optional per-beat timeout and mem_err port via MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_BASE = DATA_BASE_DEF,
  parameter int ADDR_W    = 18,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              WB_EN_in,
  input  logic [4:0]        Dest_in,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       ST_val,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              WB_EN,
  output logic              MEM_R_EN_out,
  output logic [4:0]        Dest,
  output logic [31:0]       ALU_result_out,
  output logic [31:0]       MEM_result
`ifdef MEM_STAGE_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);

  logic        idle;
  logic        busy;
  logic        beat;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [31:0] offset;
  logic        unused_addr;

  mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (MEM_R_EN),
    .wr_en     (MEM_W_EN),
    .st_val    (ST_val),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .idle      (idle),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .beat      (beat),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .mem_err   (mem_err)
`endif
  );

  // Byte offset into data memory; bits [1:0] are dropped since accesses are aligned.
  assign offset      = ALU_result - 32'(DATA_BASE);
  assign mem_addr    = mem_req ? {offset[ADDR_W:2], beat} : '0;
  assign unused_addr = ^offset;

  // Combinational so upstream registers hold the instruction in its first cycle.
  assign freeze = (idle & (MEM_R_EN | MEM_W_EN)) | busy;

  // MEM/WB register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN          <= 1'b0;
      MEM_R_EN_out   <= 1'b0;
      Dest           <= '0;
      ALU_result_out <= '0;
      MEM_result     <= '0;
    end else begin
      if (!freeze) begin
        WB_EN          <= WB_EN_in;
        MEM_R_EN_out   <= MEM_R_EN;
        Dest           <= Dest_in;
        ALU_result_out <= ALU_result;
      end
      if (ld_valid)
        MEM_result <= ld_data;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a memory-array reference model.
// Covers the MEM_STAGE_TIMEOUT_EN build when that macro is defined.
module tb_mem_stage;

  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              MEM_R_EN, MEM_W_EN, WB_EN_in;
  logic [4:0]        Dest_in;
  logic [31:0]       ALU_result, ST_val;
  logic              freeze, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata, mem_rdata;
  logic              mem_ack;
  logic              WB_EN, MEM_R_EN_out;
  logic [4:0]        Dest;
  logic [31:0]       ALU_result_out, MEM_result;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic              mem_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_res;
  logic [15:0] mem_model [int];

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_BASE (1024),
    .ADDR_W    (ADDR_W),
`ifdef MEM_STAGE_TIMEOUT_EN
    .TIMEOUT   (4)
`else
    .TIMEOUT   (64)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_R_EN       (MEM_R_EN),
    .MEM_W_EN       (MEM_W_EN),
    .WB_EN_in       (WB_EN_in),
    .Dest_in        (Dest_in),
    .ALU_result     (ALU_result),
    .ST_val         (ST_val),
    .freeze         (freeze),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .WB_EN          (WB_EN),
    .MEM_R_EN_out   (MEM_R_EN_out),
    .Dest           (Dest),
    .ALU_result_out (ALU_result_out),
    .MEM_result     (MEM_result)
`ifdef MEM_STAGE_TIMEOUT_EN
    ,
    .mem_err        (mem_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   mem_req, 0);
    chk({tag, "_we"},    mem_we, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wb"},    WB_EN, 0);
    chk({tag, "_mr"},    MEM_R_EN_out, 0);
    chk({tag, "_dest"},  Dest, 0);
    chk({tag, "_alu"},   ALU_result_out, 0);
    chk({tag, "_res"},   MEM_result, 0);
  endtask

  // Caller is at a negedge; returns at the negedge after the instruction retires.
  task automatic run_instr(input bit r, input bit w, input bit wb, input logic [4:0] d,
                           input logic [31:0] alu, input logic [31:0] st,
                           input int d0, input int d1);
    int   dly [2];
    int   beat = 0, waitc = 0, fcnt = 0, cyc = 0;
    bit   done = 0;
    bit   is_mem = r | w;
    logic [15:0] lo_v = '0, hi_v = '0, half;
    logic [31:0] widx;
    int   a;
    dly[0] = d0;
    dly[1] = d1;
    widx = ((alu - 32'd1024) >> 2) & 32'h0001_FFFF;
    MEM_R_EN = r; MEM_W_EN = w; WB_EN_in = wb; Dest_in = d;
    ALU_result = alu; ST_val = st;
    while (!done) begin
      #1;
      if (freeze) fcnt++;
      if (mem_req) begin
        if (beat > 1) begin
          chk("extra_req", mem_req, 0);
          mem_ack = 1'b0;
        end else begin
          a = int'(widx) * 2 + beat;
          half = (beat == 1) ? st[31:16] : st[15:0];
          chk("addr", mem_addr, a);
          chk("we", mem_we, w);
          chk("wdata", mem_wdata, half);
          if (waitc == dly[beat]) begin
            mem_ack = 1'b1;
            if (w) begin
              mem_model[a] = half;
              mem_rdata = 16'($urandom);
            end else begin
              if (!mem_model.exists(a)) mem_model[a] = 16'($urandom);
              mem_rdata = mem_model[a];
            end
            if (beat == 0) lo_v = mem_rdata; else hi_v = mem_rdata;
            beat++;
            waitc = 0;
          end else begin
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            waitc++;
          end
        end
      end else begin
        chk("idle_addr", mem_addr, 0);
        chk("idle_we", mem_we, 0);
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      done = !freeze;
      @(posedge clk);
      cyc++;
      if (cyc > 200) begin
        chk("retire_budget", cyc, 0);
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    @(negedge clk);
    if (r && !w) exp_res = {hi_v, lo_v};
    chk("freeze_cycles", fcnt, is_mem ? 3 + d0 + d1 : 0);
    chk("wb_en", WB_EN, wb);
    chk("mem_r_en_out", MEM_R_EN_out, r);
    chk("dest", Dest, d);
    chk("alu_out", ALU_result_out, alu);
    chk("mem_result", MEM_result, exp_res);
    chk("req_after", mem_req, 0);
  endtask

  initial begin
    int r, w, sel;
    rst = 1'b1;
    MEM_R_EN = 0; MEM_W_EN = 0; WB_EN_in = 0; Dest_in = 0;
    ALU_result = 0; ST_val = 0; mem_rdata = 0; mem_ack = 0;
    exp_res = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_freeze", freeze, 0);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory pass-through
    run_instr(0, 0, 1, 5'd5, 32'h0000_0040, 32'h0, 0, 0);

    // Async reset mid-cycle clears the MEM/WB register before any edge
    WB_EN_in = 0; Dest_in = 0; ALU_result = 0;
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_res = '0;

    // Store 0x12345678 to 1032, immediate ack: beats at half-words 4 and 5
    run_instr(0, 1, 0, 5'd0, 32'd1032, 32'h1234_5678, 0, 0);
    chk("store_lo", mem_model[4], 16'h5678);
    chk("store_hi", mem_model[5], 16'h1234);

    // Load from 1024 with two-cycle ack delay on each beat
    mem_model[0] = 16'hBEEF;
    mem_model[1] = 16'hCAFE;
    run_instr(1, 0, 1, 5'd9, 32'd1024, 32'h0, 2, 2);
    chk("load_cafebeef", MEM_result, 32'hCAFE_BEEF);

    // Reset while in HI abandons the access
    MEM_R_EN = 1; MEM_W_EN = 0; ALU_result = 32'd1032; mem_ack = 0;
    @(negedge clk);
    #1 chk("rh_lo_req", mem_req, 1);
    mem_ack = 1; mem_rdata = 16'h1111;
    @(negedge clk);
    mem_ack = 0;
    #1 chk("rh_hi_addr", mem_addr, 5);
    #2 rst = 1'b1;
    #1 chk("rh_req_drop", mem_req, 0);
    chk_all_zero("rh_rst");
    @(negedge clk);
    MEM_R_EN = 0;
    rst = 1'b0;
    exp_res = '0;
    mem_model[4] = 16'h0F0F;
    mem_model[5] = 16'hA5A5;
    run_instr(1, 0, 1, 5'd3, 32'd1032, 32'h0, 1, 0);
    chk("rh_reload", MEM_result, 32'hA5A5_0F0F);

    // Randomized instruction mix
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      r = (sel == 1) || (sel == 3);
      w = (sel == 2) || (sel == 3);
      run_instr(r[0], w[0], 1'($urandom), 5'($urandom),
                32'd1024 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3)),
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    begin
      int fc = 0, cy = 0;
      MEM_R_EN = 1; MEM_W_EN = 0; ALU_result = 32'd1024; mem_ack = 0;
      chk("tmo_err_pre", mem_err, 0);
      #1;
      while (freeze && cy < 50) begin
        fc++;
        @(negedge clk);
        #1;
        cy++;
      end
      chk("tmo_freeze", fc, 5);
      @(negedge clk);
      chk("tmo_poison", MEM_result, 32'hDEAD_BEEF);
      chk("tmo_err", mem_err, 1);
      MEM_R_EN = 0;
      repeat (2) @(negedge clk);
      chk("tmo_err_sticky", mem_err, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
